// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: plays one of three fixed (period, frames) step
// tables on a square-wave tone generator. Triggers latch into pending flags
// and are served highest priority first (DIE > HIT > EAT). A pending effect
// that is higher than or equal to the one playing preempts or restarts it.
module sfx_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       eat_trig,
  input  logic       hit_trig,
  input  logic       die_trig,
  input  logic       mute,
  output logic       tone_en,
  output logic [9:0] tone_period,
  output logic [1:0] active_sfx,
  output logic       busy,
  output logic       sfx_done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;

  // Effect codes double as pending-bit indices and as priority ranks.
  localparam logic [1:0] SFX_NONE = 2'd0;
  localparam logic [1:0] SFX_EAT  = 2'd1;
  localparam logic [1:0] SFX_HIT  = 2'd2;
  localparam logic [1:0] SFX_DIE  = 2'd3;

  state_t      r_state;
  logic [3:1]  r_pend;
  logic [1:0]  r_step;
  logic [4:0]  r_cnt;
  logic        r_tone_en;
  logic [9:0]  r_period;
  logic [1:0]  r_active;
  logic        r_done;

  logic [3:1]  w_trig;
  logic        w_any_trig;
  logic        w_tick;
  logic [1:0]  w_sel;
  logic [3:1]  w_clr;
  logic        w_preempt;
  logic [1:0]  w_next_step;
  logic [14:0] w_load_ent;
  logic [14:0] w_next_ent;

  // Step table entry packed as {period[9:0], frames[4:0]}.
  function automatic logic [14:0] step_lut(input logic [1:0] sfx, input logic [1:0] step);
    logic [14:0] ent;
    ent = '0;
    case (sfx)
      SFX_EAT: case (step)
        2'd0:    ent = {10'd200, 5'd4};
        2'd1:    ent = {10'd150, 5'd4};
        default: ent = {10'd100, 5'd6};
      endcase
      SFX_HIT: case (step)
        2'd0:    ent = {10'd400, 5'd3};
        default: ent = {10'd600, 5'd3};
      endcase
      SFX_DIE: case (step)
        2'd0:    ent = {10'd300, 5'd8};
        2'd1:    ent = {10'd400, 5'd8};
        2'd2:    ent = {10'd500, 5'd8};
        default: ent = {10'd700, 5'd16};
      endcase
      default: ent = '0;
    endcase
    return ent;
  endfunction

  // Index of the final step of each effect.
  function automatic logic [1:0] last_step(input logic [1:0] sfx);
    case (sfx)
      SFX_EAT: return 2'd2;
      SFX_HIT: return 2'd1;
      SFX_DIE: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  assign w_trig      = {die_trig, hit_trig, eat_trig};
  assign w_any_trig  = |w_trig;
  // A frame tick coinciding with any trigger is dropped.
  assign w_tick      = frame_tick & ~w_any_trig;
  assign w_next_step = r_step + 2'd1;
  assign w_load_ent  = step_lut(w_sel, 2'd0);
  assign w_next_ent  = step_lut(r_active, w_next_step);
  // Equal priority counts too: that is the retrigger/restart case.
  assign w_preempt   = (w_sel != SFX_NONE) && (w_sel >= r_active);

  // Highest-priority pending effect and the flag LOAD consumes.
  always_comb begin
    w_sel = SFX_NONE;
    w_clr = '0;
    if      (r_pend[3]) w_sel = SFX_DIE;
    else if (r_pend[2]) w_sel = SFX_HIT;
    else if (r_pend[1]) w_sel = SFX_EAT;
    if (r_state == S_LOAD && w_sel != SFX_NONE) w_clr[w_sel] = 1'b1;
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pend    <= '0;
      r_step    <= '0;
      r_cnt     <= '0;
      r_tone_en <= 1'b0;
      r_period  <= '0;
      r_active  <= SFX_NONE;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // New triggers win over the flag being consumed on the same edge.
      r_pend <= (r_pend & ~w_clr) | w_trig;
      case (r_state)
        S_IDLE: if (|r_pend) r_state <= S_LOAD;
        S_LOAD: begin
          if (w_sel == SFX_NONE) begin
            r_state <= S_IDLE;
          end else begin
            r_active  <= w_sel;
            r_step    <= 2'd0;
            r_cnt     <= w_load_ent[4:0];
            r_period  <= w_load_ent[14:5];
            r_tone_en <= ~mute;
            r_state   <= S_PLAY;
          end
        end
        S_PLAY: begin
          r_tone_en <= ~mute;
          if (w_preempt) begin
            // Current effect is abandoned silently; LOAD picks the new one.
            r_state <= S_LOAD;
          end else if (w_tick) begin
            if (r_cnt == 5'd1) begin
              if (r_step == last_step(r_active)) begin
                // Period is left holding its last value.
                r_active  <= SFX_NONE;
                r_tone_en <= 1'b0;
                r_done    <= 1'b1;
                r_step    <= 2'd0;
                r_cnt     <= 5'd0;
                r_state   <= (|r_pend) ? S_LOAD : S_IDLE;
              end else begin
                r_step   <= w_next_step;
                r_cnt    <= w_next_ent[4:0];
                r_period <= w_next_ent[14:5];
              end
            end else begin
              r_cnt <= r_cnt - 5'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tone_en     = r_tone_en;
  assign tone_period = r_period;
  assign active_sfx  = r_active;
  assign busy        = (r_active != SFX_NONE);
  assign sfx_done    = r_done;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer: each step drives inputs just after a
// rising edge and checks registered outputs 1ns after the following edge.
module tb_sfx_sequencer;

  logic       clk = 1'b0;
  logic       reset, frame_tick, eat_trig, hit_trig, die_trig, mute;
  logic       tone_en, busy, sfx_done;
  logic [9:0] tone_period;
  logic [1:0] active_sfx;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int d0;

  sfx_sequencer dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .eat_trig(eat_trig), .hit_trig(hit_trig), .die_trig(die_trig),
    .mute(mute), .tone_en(tone_en), .tone_period(tone_period),
    .active_sfx(active_sfx), .busy(busy), .sfx_done(sfx_done)
  );

  always #5 clk = ~clk;

  // Running count of completion pulses (lags the pulse by one edge).
  always @(posedge clk) if (sfx_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // One frame tick; returns just after the edge that consumed it.
  task automatic tick1();
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin tick1(); cyc(); end
  endtask

  task automatic outs(input string tag, input logic en, input logic [9:0] per,
                      input logic [1:0] act, input logic dn);
    chk({tag, ".tone_en"}, tone_en, en);
    chk({tag, ".period"}, tone_period, per);
    chk({tag, ".active"}, active_sfx, act);
    chk({tag, ".busy"}, busy, act != 2'd0);
    chk({tag, ".done"}, sfx_done, dn);
  endtask

  initial begin
    reset = 1'b1; frame_tick = 0; eat_trig = 0; hit_trig = 0; die_trig = 0; mute = 0;
    cyc(); cyc();
    outs("reset", 0, 10'd0, 2'd0, 0);
    reset = 1'b0;
    cyc(); cyc();

    // Frame ticks alone do nothing when idle.
    ticks(2);
    outs("idle_tick", 0, 10'd0, 2'd0, 0);

    // EAT from idle: audible two edges after the trigger.
    eat_trig = 1; cyc(); eat_trig = 0;
    outs("eat_t0", 0, 10'd0, 2'd0, 0);
    cyc();
    outs("eat_t1", 0, 10'd0, 2'd0, 0);
    cyc();
    outs("eat_t2", 1, 10'd200, 2'd1, 0);
    ticks(4);
    outs("eat_s1", 1, 10'd150, 2'd1, 0);
    ticks(4);
    outs("eat_s2", 1, 10'd100, 2'd1, 0);
    ticks(5);
    outs("eat_13", 1, 10'd100, 2'd1, 0);
    tick1();
    outs("eat_done", 0, 10'd100, 2'd0, 1);
    cyc();
    outs("eat_after", 0, 10'd100, 2'd0, 0);

    // HIT preempts EAT; EAT is neither completed nor re-pended.
    d0 = done_cnt;
    eat_trig = 1; cyc(); eat_trig = 0; cyc(); cyc();
    ticks(2);
    outs("pre_eat", 1, 10'd200, 2'd1, 0);
    hit_trig = 1; cyc(); hit_trig = 0;
    chk("pre_t0.active", active_sfx, 2'd1);
    cyc(); cyc();
    outs("pre_hit", 1, 10'd400, 2'd2, 0);
    ticks(3);
    outs("pre_hit_s1", 1, 10'd600, 2'd2, 0);
    ticks(2);
    tick1();
    outs("pre_hit_done", 0, 10'd600, 2'd0, 1);
    cyc(); cyc(); cyc();
    outs("pre_idle", 0, 10'd600, 2'd0, 0);
    chk("pre_done_cnt", done_cnt - d0, 1);

    // DIE with two EAT triggers pending: DIE, then a single EAT.
    d0 = done_cnt;
    die_trig = 1; cyc(); die_trig = 0; cyc(); cyc();
    outs("die_s0", 1, 10'd300, 2'd3, 0);
    eat_trig = 1; cyc(); eat_trig = 0; cyc();
    eat_trig = 1; cyc(); eat_trig = 0; cyc();
    chk("die_low_pend.active", active_sfx, 2'd3);
    ticks(39);
    outs("die_39", 1, 10'd700, 2'd3, 0);
    tick1();
    outs("die_done", 0, 10'd700, 2'd0, 1);
    cyc();
    outs("pend_eat", 1, 10'd200, 2'd1, 0);
    ticks(13);
    tick1();
    outs("pend_eat_done", 0, 10'd100, 2'd0, 1);
    cyc(); cyc(); cyc();
    outs("pend_idle", 0, 10'd100, 2'd0, 0);
    chk("die_eat_done_cnt", done_cnt - d0, 2);

    // Simultaneous triggers, with a frame tick that must be ignored.
    d0 = done_cnt;
    eat_trig = 1; hit_trig = 1; die_trig = 1; frame_tick = 1;
    cyc();
    eat_trig = 0; hit_trig = 0; die_trig = 0; frame_tick = 0;
    cyc(); cyc();
    outs("all_die", 1, 10'd300, 2'd3, 0);
    ticks(39);
    tick1();
    outs("all_die_done", 0, 10'd700, 2'd0, 1);
    cyc();
    outs("all_hit", 1, 10'd400, 2'd2, 0);
    ticks(5);
    tick1();
    outs("all_hit_done", 0, 10'd600, 2'd0, 1);
    cyc();
    outs("all_eat", 1, 10'd200, 2'd1, 0);
    ticks(13);
    tick1();
    outs("all_eat_done", 0, 10'd100, 2'd0, 1);
    cyc(); cyc();
    chk("all_done_cnt", done_cnt - d0, 3);
    chk("all_idle.active", active_sfx, 2'd0);

    // Muted HIT with a mid-effect restart.
    mute = 1;
    hit_trig = 1; cyc(); hit_trig = 0; cyc(); cyc();
    outs("mute_hit", 0, 10'd400, 2'd2, 0);
    ticks(2);
    outs("mute_hit2", 0, 10'd400, 2'd2, 0);
    hit_trig = 1; cyc(); hit_trig = 0; cyc(); cyc();
    tick1();
    outs("restart_t1", 0, 10'd400, 2'd2, 0);
    cyc();
    ticks(2);
    outs("restart_s1", 0, 10'd600, 2'd2, 0);
    ticks(2);
    tick1();
    outs("mute_done", 0, 10'd600, 2'd0, 1);
    cyc();

    // Mute toggled while playing: one-cycle latency, sequencing unaffected.
    mute = 0;
    eat_trig = 1; cyc(); eat_trig = 0; cyc(); cyc();
    outs("unmute_eat", 1, 10'd200, 2'd1, 0);
    mute = 1; cyc();
    outs("mute_on", 0, 10'd200, 2'd1, 0);
    mute = 0; cyc();
    outs("mute_off", 1, 10'd200, 2'd1, 0);

    // Reset mid-DIE (step 2), with a coincident trigger that is discarded.
    die_trig = 1; cyc(); die_trig = 0; cyc(); cyc();
    ticks(16);
    outs("die_step2", 1, 10'd500, 2'd3, 0);
    d0 = done_cnt;
    reset = 1; hit_trig = 1; cyc(); reset = 0; hit_trig = 0;
    outs("rst_mid", 0, 10'd0, 2'd0, 0);
    cyc(); cyc();
    ticks(1);
    cyc(); cyc();
    outs("rst_idle", 0, 10'd0, 2'd0, 0);
    chk("rst_no_done", done_cnt - d0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sfx_sequencer.md
SFX_SEQUENCER -- requirements
Module: sfx_sequencer

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 frame_tick  input  1  one-cycle pulse per video frame; time base for note durations.
REQ-004 eat_trig  input  1  one-cycle request for EAT effect (sheep eaten).
REQ-005 hit_trig  input  1  one-cycle request for HIT effect (sword strikes dragon).
REQ-006 die_trig  input  1  one-cycle request for DIE effect (player killed).
REQ-007 mute  input  1  level; 1 silences output without stopping sequencing.
REQ-008 tone_en  output  1  square-wave generator enable; 0 means silence.
REQ-009 tone_period  output  10  half-period for the tone generator, in generator ticks.
REQ-010 active_sfx  output  2  effect playing: 0 none, 1 EAT, 2 HIT, 3 DIE.
REQ-011 busy  output  1  1 while any effect is playing (active_sfx != 0).
REQ-012 sfx_done  output  1  one-cycle pulse when an effect completes its last step.

Function
REQ-013 Effects SHALL be fixed step tables, each step = (period, frames):
  EAT: (200,4) (150,4) (100,6); HIT: (400,3) (600,3); DIE: (300,8) (400,8) (500,8) (700,16).
REQ-014 Priority SHALL be DIE > HIT > EAT.
REQ-015 FSM SHALL have states IDLE, LOAD, PLAY; IDLE->LOAD when any pending bit set; LOAD->PLAY unconditionally; PLAY->LOAD on preempt or retrigger; PLAY->IDLE after last step with no pending; PLAY->LOAD after last step with pending.
REQ-016 A trigger sampled at edge t SHALL set its pending bit at t; from IDLE, tone_en/tone_period/active_sfx SHALL reflect step 0 of that effect from edge t+2.
REQ-017 LOAD SHALL select highest-priority pending bit, clear it, set step index 0, load frame counter with step 0 frames.
REQ-018 In PLAY, each frame_tick SHALL decrement the frame counter; tick with counter == 1 advances to the next step (load its period and frames) on the same edge.
REQ-019 Advancing past the last step SHALL clear active_sfx and tone_en and pulse sfx_done for exactly one cycle on that edge.
REQ-020 Trigger of higher priority than active_sfx SHALL preempt: current effect abandoned (not re-pended, no sfx_done), new effect audible 2 cycles after trigger.
REQ-021 Trigger of the same effect as active_sfx SHALL restart it from step 0 (no sfx_done).
REQ-022 Trigger of lower priority than active_sfx SHALL only set its pending bit; served after current effect completes, highest priority first.
REQ-023 Pending bits SHALL be single flags; repeated triggers of one effect while pending collapse to one play.
REQ-024 Simultaneous triggers SHALL start the highest priority and pend the rest; a frame_tick on the same cycle as a trigger or in LOAD SHALL be ignored.
REQ-025 mute SHALL force tone_en to 0 combinationally-free (registered, 1-cycle latency) while step timing, sfx_done and active_sfx continue unchanged.
REQ-026 tone_period SHALL hold its last value when tone_en is 0.

Reset
REQ-027 On reset: state IDLE, pending bits 0, tone_en 0, tone_period 0, active_sfx 0, busy 0, sfx_done 0, counters 0.
REQ-028 Reset asserted mid-effect SHALL abort it on the next edge with no sfx_done pulse; triggers coincident with reset SHALL be discarded.

Verification
REQ-029 eat_trig at cycle 10 from IDLE -> cycle 12 tone_en=1, tone_period=200, active_sfx=1; after 14 frame_ticks sfx_done pulses once, busy=0.
REQ-030 EAT playing, hit_trig -> within 2 cycles tone_period=400, active_sfx=2; no sfx_done for EAT; after 6 ticks sfx_done, then IDLE.
REQ-031 DIE playing, eat_trig twice -> DIE finishes (40 ticks, sfx_done), then one EAT plays (14 ticks, second sfx_done), then IDLE.
REQ-032 eat_trig, hit_trig, die_trig same cycle -> DIE, then HIT, then EAT, three sfx_done pulses in order.
REQ-033 HIT playing, mute=1 for full effect -> tone_en=0 throughout, sfx_done still after 6 ticks; hit_trig mid-effect restarts at period 400.
REQ-034 reset during DIE step 2 -> next edge all outputs 0, no sfx_done; frame_tick with no trigger afterwards -> stays IDLE.
